sobel_line_buffer: RTL and testbench
====================================

// Module: sobel_line_buffer
// PURPOSE
//   Upstream of the 3x3 window/zero-padding stage. Takes a raster pixel stream and emits
//   column-aligned pixel triplets (newest, previous and oldest row) from two on-chip row buffers.
//   Appends one flush row at end of frame so the last image row is also centred in a window.
// PARAMETERS
//   ROWS  default 480  image height in pixels (>=3)
//   COLS  default 640  image width in pixels (>=3, <=1024)
// PORTS
//   clk      in   1  clock, all logic on posedge
//   rst      in   1  synchronous reset, active-high
//   d_i      in   8  input pixel, raster order
//   done_i   in   1  d_i valid this cycle; ignored when ready_o=0
//   ready_o  out  1  block accepts done_i (0 only during FLUSH)
//   d0_o     out  8  pixel of current row r at column c (bottom of window)
//   d1_o     out  8  pixel of row r-1 at column c (middle)
//   d2_o     out  8  pixel of row r-2 at column c (top)
//   done_o   out  1  d0_o..d2_o valid, 1-cycle pulse per beat
// BEHAVIOUR
//   - Reset: d0_o=d1_o=d2_o=0, done_o=0, ready_o=1, state=PRIME, in_col=in_row=0 (10-bit counters).
//   - Row buffers rb1 (last row) and rb2 (row before): COLS x 8, async read, sync write, shared
//     column index in_col. Contents are not cleared by reset.
//   - Accepted beat (done_i & ready_o) at column c:
//     PRIME (in_row==0): rb1[c]<=d_i, rb2[c]<=0; done_o stays 0.
//     RUN   (in_row>=1): d0_o<=d_i, d1_o<=rb1[c], d2_o<=rb2[c], done_o<=1;
//                        rb2[c]<=rb1[c], rb1[c]<=d_i (read-before-write).
//   - Latency: outputs registered, 1 cycle after the accepted beat. Gaps in done_i allowed;
//     outputs hold their last value while done_o=0.
//   - in_col wraps at COLS-1 -> 0 and increments in_row. The first row-1 beat therefore emits
//     d2_o=0.
//   - State transitions:
//     PRIME -> RUN on the accepted beat at c=COLS-1.
//     RUN -> FLUSH on the accepted beat at (ROWS-1, COLS-1).
//   - FLUSH: ready_o=0; one beat per cycle for c=0..COLS-1.
//     d0_o<=0, d1_o<=rb1[c], d2_o<=rb2[c], done_o<=1. Buffers are not written.
//     After beat COLS-1: state=PRIME, counters=0, ready_o=1.
//   - done_i while ready_o=0 is dropped: no counter, buffer or output effect.
//   - Each frame produces exactly ROWS*COLS done_o beats, matching the window stage's count.
//   - rst asserted mid-frame, including during FLUSH: returns immediately to reset state.
//     The next accepted pixel is frame row 0, col 0.
// CONFIGURATION
//   SOBEL_LB_FRAME_MARK_EN defined: adds outputs sof_o and eof_o (1 bit each, reset 0).
//     sof_o pulses with the first done_o of a frame; eof_o pulses with the last FLUSH beat.
//   Undefined: ports absent, behaviour otherwise identical.
// STRUCTURE
//   Package sobel_pkg: PIX_W=8, CNT_W=10, state localparams ST_PRIME/ST_RUN/ST_FLUSH (2 bits).
//   Sub-module sobel_row_ram (COLS x PIX_W, async read, sync write), instantiated twice (rb1, rb2).
//   Top level holds the counters, the FSM and the output registers.
// TESTING (ROWS=4, COLS=4, pixel value = 16*row+col)
//   - Reset: after rst, outputs 0, done_o=0, ready_o=1; 4 row-0 beats -> no done_o.
//   - Row 1, col 2 beat (d_i=18) -> next cycle d0_o=18, d1_o=2, d2_o=0, done_o=1.
//   - Row 3, col 1 beat (d_i=49) -> next cycle d0_o=49, d1_o=33, d2_o=17.
//   - After d_i=51 -> ready_o=0; 4 consecutive beats d0_o=0, d1_o=48..51, d2_o=32..35;
//     then ready_o=1; 16 done_o per frame.
//   - done_i held high through FLUSH, and done_i toggling every other cycle ->
//     identical output sequence, dropped beats have no effect.
//   - rst in row 2, then a fresh frame -> first done_o on row 1 col 0 with d2_o=0;
//     with SOBEL_LB_FRAME_MARK_EN, sof_o/eof_o exactly once per frame.

Source files
------------

// File: rtl/sobel_line_buffer_pkg.sv
// Shared definitions for the Sobel line buffer: pixel/counter widths and FSM encodings.
package sobel_pkg;

    localparam int PIX_W = 8;
    localparam int CNT_W = 10;

    typedef logic [1:0] state_t;

    localparam state_t ST_PRIME = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_FLUSH = 2'd2;

endpackage

// File: rtl/sobel_line_buffer_if.sv
// Pixel-stream interface into the line buffer and triplet stream out of it.
// With SOBEL_LB_FRAME_MARK_EN defined, start/end-of-frame marks are carried as well.
interface sobel_line_buffer_if;
    import sobel_pkg::*;

    logic [PIX_W-1:0] d_i;
    logic             done_i;
    logic             ready_o;
    logic [PIX_W-1:0] d0_o;
    logic [PIX_W-1:0] d1_o;
    logic [PIX_W-1:0] d2_o;
    logic             done_o;
`ifdef SOBEL_LB_FRAME_MARK_EN
    logic             sof_o;
    logic             eof_o;
`endif

    modport master (
        output d_i, done_i,
        input  ready_o, d0_o, d1_o, d2_o, done_o
`ifdef SOBEL_LB_FRAME_MARK_EN
        , input sof_o, eof_o
`endif
    );

    modport slave (
        input  d_i, done_i,
        output ready_o, d0_o, d1_o, d2_o, done_o
`ifdef SOBEL_LB_FRAME_MARK_EN
        , output sof_o, eof_o
`endif
    );

endinterface

// File: rtl/sobel_row_ram.sv
// One image row of pixel storage: asynchronous read, synchronous write.
module sobel_row_ram
    import sobel_pkg::*;
#(
    parameter int COLS = 640,
    localparam int AW  = $clog2(COLS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [COLS];

    // write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sobel_line_buffer.sv
// Sobel line buffer: turns a raster pixel stream into column-aligned triplets
// (row r, r-1, r-2) and appends one flush row per frame.
// Optional feature macro: SOBEL_LB_FRAME_MARK_EN (adds sof_o / eof_o).
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int ROWS = 480,
    parameter int COLS = 640
) (
    input  logic               clk,
    input  logic               rst,
    sobel_line_buffer_if.slave bus
);

    localparam int AW = $clog2(COLS);
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(COLS - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROWS - 1);

    state_t           state_q, state_nx;
    logic [CNT_W-1:0] in_col, in_row;
    logic             ready, accept, rb_we;
    logic             col_last, row_last;
    logic [PIX_W-1:0] rb1_rd, rb2_rd, rb2_wd;
    logic [PIX_W-1:0] d0_p1, d1_p1, d2_p1;
    logic             vld_p1;

    assign col_last = (in_col == COL_LAST);
    assign row_last = (in_row == ROW_LAST);

    sobel_row_ram #(.COLS(COLS)) u_rb1 (
        .clk(clk), .we(rb_we), .addr(in_col[AW-1:0]), .wdata(bus.d_i), .rdata(rb1_rd)
    );

    sobel_row_ram #(.COLS(COLS)) u_rb2 (
        .clk(clk), .we(rb_we), .addr(in_col[AW-1:0]), .wdata(rb2_wd), .rdata(rb2_rd)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_PRIME;
        else     state_q <= state_nx;
    end

    // next-state: prime one row, run to the last pixel, then flush one row
    always_comb begin
        state_nx = state_q;
        case (state_q)
            ST_PRIME: if (accept && col_last)             state_nx = ST_RUN;
            ST_RUN:   if (accept && col_last && row_last) state_nx = ST_FLUSH;
            ST_FLUSH: if (col_last)                       state_nx = ST_PRIME;
            default:                                      state_nx = ST_PRIME;
        endcase
    end

    // FSM outputs: handshake and buffer write control (rb2 starts zeroed while priming)
    always_comb begin
        ready  = (state_q != ST_FLUSH);
        accept = bus.done_i & ready;
        rb_we  = accept;
        rb2_wd = (state_q == ST_PRIME) ? '0 : rb1_rd;
    end

    // column/row counters; flush walks the columns on its own
    always_ff @(posedge clk) begin
        if (rst) begin
            in_col <= '0;
            in_row <= '0;
        end else if (accept || state_q == ST_FLUSH) begin
            if (col_last) begin
                in_col <= '0;
                in_row <= (state_q == ST_FLUSH || row_last) ? '0 : in_row + 1'b1;
            end else begin
                in_col <= in_col + 1'b1;
            end
        end
    end

    // ---- stage p1: registered triplet output ----
    always_ff @(posedge clk) begin
        if (rst) begin
            d0_p1  <= '0;
            d1_p1  <= '0;
            d2_p1  <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            if (accept && state_q == ST_RUN) begin
                d0_p1  <= bus.d_i;
                d1_p1  <= rb1_rd;
                d2_p1  <= rb2_rd;
                vld_p1 <= 1'b1;
            end else if (state_q == ST_FLUSH) begin
                d0_p1  <= '0;
                d1_p1  <= rb1_rd;
                d2_p1  <= rb2_rd;
                vld_p1 <= 1'b1;
            end
        end
    end

    assign bus.ready_o = ready;
    assign bus.d0_o    = d0_p1;
    assign bus.d1_o    = d1_p1;
    assign bus.d2_o    = d2_p1;
    assign bus.done_o  = vld_p1;

`ifdef SOBEL_LB_FRAME_MARK_EN
    logic sof_p1, eof_p1;

    // frame marks: first output beat is row 1 col 0, last is the final flush column
    always_ff @(posedge clk) begin
        if (rst) begin
            sof_p1 <= 1'b0;
            eof_p1 <= 1'b0;
        end else begin
            sof_p1 <= accept && state_q == ST_RUN && in_row == CNT_W'(1) && in_col == '0;
            eof_p1 <= state_q == ST_FLUSH && col_last;
        end
    end

    assign bus.sof_o = sof_p1;
    assign bus.eof_o = eof_p1;
`endif

endmodule

// File: tb/tb_sobel_line_buffer.sv
// Scoreboard bench for sobel_line_buffer with ROWS=4, COLS=4, pixel = base + 16*row + col.
module tb_sobel_line_buffer;
    import sobel_pkg::*;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    typedef struct packed {
        logic       sof;
        logic       eof;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] d2;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   beats  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    sobel_line_buffer_if bus();

    sobel_line_buffer #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int base, input int r, input int c);
        return 8'(base + 16 * r + c);
    endfunction

    // output monitor: every done_o beat must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && bus.done_o === 1'b1) begin
            beats++;
            if (sb.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("d0", bus.d0_o, e.d0);
                chk("d1", bus.d1_o, e.d1);
                chk("d2", bus.d2_o, e.d2);
`ifdef SOBEL_LB_FRAME_MARK_EN
                chk("sof", bus.sof_o, e.sof);
                chk("eof", bus.eof_o, e.eof);
`endif
            end
        end
`ifdef SOBEL_LB_FRAME_MARK_EN
        else if (rst === 1'b0 && (bus.sof_o | bus.eof_o)) begin
            chk("mark_without_beat", 1, 0);
        end
`endif
    end

    task automatic drive_pix(input logic [7:0] v, input bit gap, input bit hold);
        int guard = 0;
        @(negedge clk);
        while (bus.ready_o !== 1'b1 && guard < 100) begin
            bus.done_i = hold;
            bus.d_i    = 8'hEE;
            guard++;
            @(negedge clk);
        end
        if (guard >= 100) chk("ready_timeout", 0, 1);
        bus.d_i    = v;
        bus.done_i = 1'b1;
        if (gap) begin
            @(negedge clk);
            bus.done_i = 1'b0;
            bus.d_i    = 8'h55;
        end
    endtask

    // drive pixels k0..k1 of a frame, pushing expectations (and flush row) as they go
    task automatic run_pixels(input int base, input int k0, input int k1, input bit gap, input bit hold);
        exp_t e;
        for (int k = k0; k <= k1; k++) begin
            int r = k / COLS;
            int c = k % COLS;
            if (r >= 1) begin
                e.sof = (r == 1 && c == 0);
                e.eof = 1'b0;
                e.d0  = pix(base, r, c);
                e.d1  = pix(base, r - 1, c);
                e.d2  = (r >= 2) ? pix(base, r - 2, c) : 8'd0;
                sb.push_back(e);
            end
            if (r == ROWS - 1 && c == COLS - 1) begin
                for (int fc = 0; fc < COLS; fc++) begin
                    e.sof = 1'b0;
                    e.eof = (fc == COLS - 1);
                    e.d0  = 8'd0;
                    e.d1  = pix(base, ROWS - 1, fc);
                    e.d2  = pix(base, ROWS - 2, fc);
                    sb.push_back(e);
                end
            end
            drive_pix(pix(base, r, c), gap, hold);
        end
    endtask

    task automatic finish_frame(input bit gap, input bit hold, input int start);
        int guard = 0;
        if (!gap) @(negedge clk);
        chk("ready_in_flush", bus.ready_o, 0);
        bus.done_i = hold;
        bus.d_i    = 8'hEE;
        while (bus.ready_o !== 1'b1 && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        bus.done_i = 1'b0;
        if (guard >= 100) chk("flush_timeout", 0, 1);
        chk("ready_after_flush", bus.ready_o, 1);
        @(negedge clk);
        chk("queue_empty", sb.size(), 0);
        chk("beats_per_frame", beats - start, ROWS * COLS);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        int start;
        rst        = 1'b1;
        bus.d_i    = '0;
        bus.done_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_d0", bus.d0_o, 0);
        chk("rst_d1", bus.d1_o, 0);
        chk("rst_d2", bus.d2_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_ready", bus.ready_o, 1);
`ifdef SOBEL_LB_FRAME_MARK_EN
        chk("rst_sof", bus.sof_o, 0);
        chk("rst_eof", bus.eof_o, 0);
`endif
        rst = 1'b0;

        // frame 1: prime row produces nothing, then full frame plus flush
        start = beats;
        run_pixels(0, 0, COLS - 1, 1'b0, 1'b0);
        @(negedge clk);
        bus.done_i = 1'b0;
        chk("prime_no_beats", beats - start, 0);
        chk("prime_ready", bus.ready_o, 1);
        run_pixels(0, COLS, ROWS * COLS - 1, 1'b0, 1'b0);
        finish_frame(1'b0, 1'b0, start);

        // frame 2: done_i held high through flush
        start = beats;
        run_pixels(0, 0, ROWS * COLS - 1, 1'b0, 1'b1);
        finish_frame(1'b0, 1'b1, start);

        // frame 3: done_i toggling every other cycle
        start = beats;
        run_pixels(0, 0, ROWS * COLS - 1, 1'b1, 1'b0);
        finish_frame(1'b1, 1'b0, start);

        // frame 4: abandoned by reset in row 2
        run_pixels(7, 0, 2 * COLS + 1, 1'b0, 1'b0);
        @(negedge clk);
        bus.done_i = 1'b0;
        @(negedge clk);
        chk("partial_queue_empty", sb.size(), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_done", bus.done_o, 0);
        chk("midrst_d1", bus.d1_o, 0);
        chk("midrst_ready", bus.ready_o, 1);
        rst = 1'b0;

        // frame 5: fresh frame after reset
        start = beats;
        run_pixels(100, 0, ROWS * COLS - 1, 1'b0, 1'b0);
        finish_frame(1'b0, 1'b0, start);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
